hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RISC-V core. It keeps a 3-entry scoreboard that shadows the destination registers of instructions in EX, MEM and WB. From the scoreboard it decides, each cycle, whether the ID stage stalls, whether a bubble is injected into the ID/EX register, and whether the fetch/decode register is flushed on a taken branch. It also freezes the whole pipeline while the data memory has not completed an access, and keeps a saturating stall-cycle counter.

---
 rtl/hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_scoreboard.sv | 55 +++++
 rtl/hazard_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encodings,
// scoreboard entry layout and the source/entry match helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StHaz   = 2'd1,
    StMwait = 2'd2
  } hazard_state_e;

  // Scoreboard entry: {wr, rd[4:0], mem}
  localparam int unsigned SbEntryW = 7;
  localparam int unsigned SbMemBit = 0;
  localparam int unsigned SbRdLsb  = 1;
  localparam int unsigned SbRdMsb  = 5;
  localparam int unsigned SbWrBit  = 6;

  typedef logic [SbEntryW-1:0] sb_entry_t;

  // x0 never creates a dependency, and unread sources are ignored.
  function automatic logic sb_match(sb_entry_t entry, logic [4:0] rs, logic used);
    return entry[SbWrBit] && (entry[SbRdMsb:SbRdLsb] == rs) && (rs != 5'd0) && used;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry shadow of the EX/MEM/WB destination registers with hold and
// bubble control, plus the RAW match comparators for both ID sources.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       hold,
  input  logic       bubble,
  input  logic       ds_valid,
  input  logic [4:0] ds_rd,
  input  logic       ds_regwrite,
  input  logic       ds_mem_access,
  input  logic [4:0] rs1,
  input  logic       rs1_used,
  input  logic [4:0] rs2,
  input  logic       rs2_used,
  output logic       rs1_hit,
  output logic       rs2_hit,
  output logic       mem_busy
);

  sb_entry_t sb_ex_q, sb_mem_q, sb_wb_q;
  sb_entry_t sb_ex_d;

  always_comb begin
    sb_ex_d = '0;
    if (ds_valid && !bubble) begin
      sb_ex_d[SbWrBit]         = ds_regwrite && (ds_rd != 5'd0);
      sb_ex_d[SbRdMsb:SbRdLsb] = ds_rd;
      sb_ex_d[SbMemBit]        = ds_mem_access;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_ex_q  <= '0;
      sb_mem_q <= '0;
      sb_wb_q  <= '0;
    end else if (!hold) begin
      sb_wb_q  <= sb_mem_q;
      sb_mem_q <= sb_ex_q;
      sb_ex_q  <= sb_ex_d;
    end
  end

  // WB still counts: the regfile write lands at the end of the WB cycle.
  assign rs1_hit = sb_match(sb_ex_q, rs1, rs1_used) | sb_match(sb_mem_q, rs1, rs1_used) |
                   sb_match(sb_wb_q, rs1, rs1_used);
  assign rs2_hit = sb_match(sb_ex_q, rs2, rs2_used) | sb_match(sb_mem_q, rs2, rs2_used) |
                   sb_match(sb_wb_q, rs2, rs2_used);

  assign mem_busy = sb_mem_q[SbMemBit];

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: freeze > RAW hazard > branch flush priority,
// registered cause state and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ds_valid,
  input  logic [4:0]       ds_rs1,
  input  logic [4:0]       ds_rs2,
  input  logic             ds_rs1_used,
  input  logic             ds_rs2_used,
  input  logic [4:0]       ds_rd,
  input  logic             ds_regwrite,
  input  logic             ds_mem_access,
  input  logic             ds_branch_taken,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             fs_ds_stall,
  output logic             fs_ds_flush,
  output logic             ds_es_bubble,
  output logic             es_ms_stall,
  output logic             ms_wb_stall,
  output logic [1:0]       hazard_state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             rs1_hit, rs2_hit, mem_busy;
  logic             freeze, hazard;
  hazard_state_e    state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q;

  hazard_scoreboard u_scoreboard (
    .clk           (clk),
    .resetn        (resetn),
    .hold          (freeze),
    .bubble        (ds_es_bubble),
    .ds_valid      (ds_valid),
    .ds_rd         (ds_rd),
    .ds_regwrite   (ds_regwrite),
    .ds_mem_access (ds_mem_access),
    .rs1           (ds_rs1),
    .rs1_used      (ds_rs1_used),
    .rs2           (ds_rs2),
    .rs2_used      (ds_rs2_used),
    .rs1_hit       (rs1_hit),
    .rs2_hit       (rs2_hit),
    .mem_busy      (mem_busy)
  );

  assign freeze = mem_busy & ~mem_ready;
  assign hazard = ds_valid & (rs1_hit | rs2_hit);

  always_comb begin
    pc_stall     = 1'b0;
    fs_ds_stall  = 1'b0;
    fs_ds_flush  = 1'b0;
    ds_es_bubble = 1'b0;
    es_ms_stall  = 1'b0;
    ms_wb_stall  = 1'b0;
    state_d      = StRun;
    // Outputs stay low throughout reset so a stall in flight is dropped at once.
    if (resetn) begin
      if (freeze) begin
        pc_stall    = 1'b1;
        fs_ds_stall = 1'b1;
        es_ms_stall = 1'b1;
        ms_wb_stall = 1'b1;
        state_d     = StMwait;
      end else if (hazard) begin
        // Branch decision uses stale operands here, so it is not acted on.
        pc_stall     = 1'b1;
        fs_ds_stall  = 1'b1;
        ds_es_bubble = 1'b1;
        state_d      = StHaz;
      end else begin
        fs_ds_flush = ds_valid & ds_branch_taken;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CntOne;
      end
    end
  end

  assign hazard_state = state_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected outputs are queued as each step is
// driven and popped when the step's outputs are sampled.
module tb_hazard_ctrl;

  localparam int unsigned CntW = 4;

  localparam logic [5:0] ONone = 6'b000000;
  localparam logic [5:0] OHaz  = 6'b110100;
  localparam logic [5:0] OFrz  = 6'b110011;
  localparam logic [5:0] OFl   = 6'b001000;

  localparam logic [1:0] SRun = 2'd0;
  localparam logic [1:0] SHaz = 2'd1;
  localparam logic [1:0] SMw  = 2'd2;

  logic            clk, resetn;
  logic            ds_valid, ds_rs1_used, ds_rs2_used, ds_regwrite, ds_mem_access;
  logic            ds_branch_taken, mem_ready;
  logic [4:0]      ds_rs1, ds_rs2, ds_rd;
  logic            pc_stall, fs_ds_stall, fs_ds_flush, ds_es_bubble, es_ms_stall, ms_wb_stall;
  logic [1:0]      hazard_state;
  logic [CntW-1:0] stall_cnt;
  logic [5:0]      outs;

  int n_cmp = 0;
  int n_bad = 0;

  string           tag_q[$];
  logic [5:0]      outs_q[$];
  logic [1:0]      st_q[$];
  logic [CntW-1:0] cnt_q[$];

  hazard_ctrl #(.CNT_W(CntW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds_valid        (ds_valid),
    .ds_rs1          (ds_rs1),
    .ds_rs2          (ds_rs2),
    .ds_rs1_used     (ds_rs1_used),
    .ds_rs2_used     (ds_rs2_used),
    .ds_rd           (ds_rd),
    .ds_regwrite     (ds_regwrite),
    .ds_mem_access   (ds_mem_access),
    .ds_branch_taken (ds_branch_taken),
    .mem_ready       (mem_ready),
    .pc_stall        (pc_stall),
    .fs_ds_stall     (fs_ds_stall),
    .fs_ds_flush     (fs_ds_flush),
    .ds_es_bubble    (ds_es_bubble),
    .es_ms_stall     (es_ms_stall),
    .ms_wb_stall     (ms_wb_stall),
    .hazard_state    (hazard_state),
    .stall_cnt       (stall_cnt)
  );

  assign outs = {pc_stall, fs_ds_stall, fs_ds_flush, ds_es_bubble, es_ms_stall, ms_wb_stall};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "bench timed out");
  end

  task automatic set_ins(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mem, input logic br);
    ds_valid        = v;
    ds_rs1          = rs1;
    ds_rs1_used     = u1;
    ds_rs2          = rs2;
    ds_rs2_used     = u2;
    ds_rd           = rd;
    ds_regwrite     = rw;
    ds_mem_access   = mem;
    ds_branch_taken = br;
  endtask

  task automatic idle_ins();
    set_ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_exp(input string tag, input logic [5:0] o, input logic [1:0] st,
                          input logic [CntW-1:0] cnt);
    tag_q.push_back(tag);
    outs_q.push_back(o);
    st_q.push_back(st);
    cnt_q.push_back(cnt);
  endtask

  task automatic pop_check();
    string           tag;
    logic [5:0]      e_o;
    logic [1:0]      e_st;
    logic [CntW-1:0] e_cnt;
    n_cmp++;
    assert (tag_q.size() != 0) else begin
      n_bad++;
      $error("FAIL queue: got empty queue, expected a pending entry");
    end
    if (tag_q.size() != 0) begin
      tag   = tag_q.pop_front();
      e_o   = outs_q.pop_front();
      e_st  = st_q.pop_front();
      e_cnt = cnt_q.pop_front();
      n_cmp++;
      assert (outs === e_o) else begin
        n_bad++;
        $error("FAIL %s outs: got %b expected %b", tag, outs, e_o);
      end
      n_cmp++;
      assert (hazard_state === e_st) else begin
        n_bad++;
        $error("FAIL %s state: got %0d expected %0d", tag, hazard_state, e_st);
      end
      n_cmp++;
      assert (stall_cnt === e_cnt) else begin
        n_bad++;
        $error("FAIL %s cnt: got %0d expected %0d", tag, stall_cnt, e_cnt);
      end
    end
  endtask

  // Called at a falling edge; checks mid-cycle, returns at the next falling edge.
  task automatic cyc(input string tag, input logic mr, input logic [5:0] o,
                     input logic [1:0] st, input logic [CntW-1:0] cnt);
    mem_ready = mr;
    push_exp(tag, o, st, cnt);
    #1;
    pop_check();
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    push_exp(tag, ONone, SRun, '0);
    #1;
    pop_check();
    @(negedge clk);
    idle_ins();
    mem_ready = 1'b1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn    = 1'b0;
    mem_ready = 1'b1;
    idle_ins();
    @(negedge clk);
    do_reset("reset_init");

    // Back-to-back RAW on x5
    set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc("raw_prod", 1'b1, ONone, SRun, 4'd0);
    set_ins(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    cyc("raw_s1", 1'b1, OHaz, SRun, 4'd0);
    cyc("raw_s2", 1'b1, OHaz, SHaz, 4'd1);
    cyc("raw_s3", 1'b1, OHaz, SHaz, 4'd2);
    cyc("raw_go", 1'b1, ONone, SHaz, 4'd3);
    idle_ins();
    cyc("raw_after", 1'b1, ONone, SRun, 4'd3);
    do_reset("reset_1");

    // x0 destination/source and unused rs2
    set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("x0_prod", 1'b1, ONone, SRun, 4'd0);
    set_ins(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    cyc("x0_cons", 1'b1, ONone, SRun, 4'd0);
    set_ins(1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("unused_rs2", 1'b1, ONone, SRun, 4'd0);
    idle_ins();
    cyc("x0_after", 1'b1, ONone, SRun, 4'd0);
    do_reset("reset_2");

    // Memory wait on a load in MEM, then a WB-stage dependency on that load
    set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    cyc("mw_load", 1'b1, ONone, SRun, 4'd0);
    idle_ins();
    cyc("mw_ex", 1'b1, ONone, SRun, 4'd0);
    cyc("mw_f1", 1'b0, OFrz, SRun, 4'd0);
    cyc("mw_f2", 1'b0, OFrz, SMw, 4'd1);
    cyc("mw_rdy", 1'b1, ONone, SMw, 4'd2);
    set_ins(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("mw_wbhaz", 1'b0, OHaz, SRun, 4'd2);
    cyc("mw_go", 1'b0, ONone, SHaz, 4'd3);
    do_reset("reset_3");

    // Taken branch without hazard; flush requires ds_valid
    set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc("br_flush", 1'b1, OFl, SRun, 4'd0);
    set_ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc("br_invalid", 1'b1, ONone, SRun, 4'd0);
    // Taken branch waiting on x9 in EX
    set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    cyc("brh_prod", 1'b1, ONone, SRun, 4'd0);
    set_ins(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc("brh_s1", 1'b1, OHaz, SRun, 4'd0);
    cyc("brh_s2", 1'b1, OHaz, SHaz, 4'd1);
    cyc("brh_s3", 1'b1, OHaz, SHaz, 4'd2);
    cyc("brh_flush", 1'b1, OFl, SHaz, 4'd3);
    idle_ins();
    cyc("brh_after", 1'b1, ONone, SRun, 4'd3);
    do_reset("reset_4");

    // Freeze takes priority over a pending hazard; hazard resumes afterwards
    set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
    cyc("fh_load", 1'b1, ONone, SRun, 4'd0);
    idle_ins();
    cyc("fh_ex", 1'b1, ONone, SRun, 4'd0);
    set_ins(1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    cyc("fh_f1", 1'b0, OFrz, SRun, 4'd0);
    cyc("fh_f2", 1'b0, OFrz, SMw, 4'd1);
    cyc("fh_h1", 1'b1, OHaz, SMw, 4'd2);
    cyc("fh_h2", 1'b1, OHaz, SHaz, 4'd3);
    cyc("fh_go", 1'b1, ONone, SHaz, 4'd4);
    do_reset("reset_5");

    // Reset asserted mid-hazard
    set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc("rm_prod", 1'b1, ONone, SRun, 4'd0);
    set_ins(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("rm_s1", 1'b1, OHaz, SRun, 4'd0);
    cyc("rm_s2", 1'b1, OHaz, SHaz, 4'd1);
    resetn = 1'b0;
    push_exp("rm_reset", ONone, SRun, 4'd0);
    #1;
    pop_check();
    @(negedge clk);
    resetn = 1'b1;
    cyc("rm_cleared", 1'b1, ONone, SRun, 4'd0);
    do_reset("reset_6");

    // Counter saturation over a 20-cycle freeze
    set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
    cyc("sat_load", 1'b1, ONone, SRun, 4'd0);
    idle_ins();
    cyc("sat_ex", 1'b1, ONone, SRun, 4'd0);
    for (int i = 0; i < 20; i++) begin
      cyc("sat_frz", 1'b0, OFrz, (i == 0) ? SRun : SMw, (i > 15) ? 4'd15 : 4'(i));
    end
    cyc("sat_rdy", 1'b1, ONone, SMw, 4'd15);
    cyc("sat_hold", 1'b1, ONone, SRun, 4'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
